regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-back side feeder for the 32-entry integer register file. It merges two result sources onto the file's single synchronous write port (wr_en / wr_addr / wr_data):
- the in-order ALU pipeline, which cannot be back-pressured;
- the load/store unit, which uses a valid/ready handshake.

LSU results are buffered in a small FIFO. The block exports a pending-destination mask for hazard detection and a starvation-driven stall request to the pipeline.

Parameters:
DATA_WIDTH, 32, width of write data.
FIFO_DEPTH, 4, LSU result buffer entries; power of 2, >= 2.
STARVE_LIMIT, 8, consecutive blocked cycles of a non-empty FIFO before stall_req fires; >= 2.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  synchronous active-high reset.
alu_valid  input  1  ALU result present this cycle; no back-pressure.
alu_rd  input  5  ALU destination register.
alu_data  input  DATA_WIDTH  ALU result.
lsu_valid  input  1  LSU result offered.
lsu_ready  output  1  block can accept LSU result.
lsu_rd  input  5  LSU destination register.
lsu_data  input  DATA_WIDTH  LSU load data.
wr_en  output  1  register-file write enable.
wr_addr  output  5  register-file write address.
wr_data  output  DATA_WIDTH  register-file write data.
lsu_pend_mask  output  32  bit r set while an LSU result for r (r != 0) sits in the FIFO.
stall_req  output  1  pipeline must hold alu_valid low in this cycle.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values, taking effect at the first edge with rst=1:
  - wr_en=0, wr_addr=0, wr_data=0, stall_req=0.
  - FIFO empty, count=0, starve counter=0.
  - lsu_ready=0 while rst is high, 1 in the first cycle after release.
  - Reset mid-operation discards all buffered LSU results; no write is issued for them.
- LSU handshake:
  - Transfer occurs on a cycle where lsu_valid & lsu_ready.
  - lsu_ready = !rst & (count != FIFO_DEPTH). It depends only on registered state; there is no same-cycle pass-through.
  - When full, lsu_ready=0, even if a pop happens in the same cycle.
  - The entry is pushed at the end of the accepting cycle.
- Selection, evaluated each cycle on current inputs and FIFO head:
  - stall_req=1 and FIFO non-empty: grant FIFO head.
  - Otherwise, alu_valid=1: grant ALU.
  - Otherwise, FIFO non-empty: grant FIFO head.
  - Otherwise: no grant.
  - alu_valid=1 together with stall_req=1 is a protocol violation (bench assertion). In that case the RTL gives the ALU priority and the counter is not cleared.
- Output register:
  - Granted rd/data are registered into wr_addr/wr_data.
  - wr_en = grant & (rd != 0). Writes to x0 are consumed but suppressed; wr_addr and wr_data still update.
  - With no grant: wr_en=0, and wr_addr/wr_data hold their values.
- Latency:
  - ALU result visible on the write port 1 cycle after alu_valid.
  - LSU result visible at the earliest 2 cycles after the accepting cycle.
- FIFO:
  - Pop happens on FIFO grant.
  - Push and pop may occur in the same cycle; count is then unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Results leave the FIFO in acceptance order.
- lsu_pend_mask:
  - Combinational OR over valid FIFO entries of one-hot(rd); the rd=0 bit is always 0.
  - Entries leave the mask in the cycle after they are popped.
  - Duplicate rd values keep the bit set until the last such entry is popped.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and the ALU is granted.
  - It clears on any FIFO pop or when the FIFO is empty.
  - Registered stall_req goes to 1 for exactly one cycle in the cycle after the counter reaches STARVE_LIMIT-1 while still blocked.
  - The counter clears in that stall cycle when the pop occurs.
  - stall_req never asserts while the FIFO is empty.

Test Plan:
- Reset sequence: hold rst 3 cycles while driving lsu_valid=1 -> no push; wr_en=0, lsu_ready=0, mask=0. Release -> lsu_ready=1 next cycle.
- ALU only: alu_valid at cycle 5 with rd=3, data=0xDEADBEEF -> cycle 6 shows wr_en=1, wr_addr=3, wr_data=0xDEADBEEF. With rd=0 -> wr_en=0.
- LSU buffering: push rd=5/0x11, rd=6/0x22, rd=7/0x33, rd=8/0x44 on back-to-back cycles with alu_valid=1 -> lsu_ready=0 after the 4th push and mask=0x1E0. Drop alu_valid -> writes 5, 6, 7, 8 appear on consecutive cycles in order and the mask clears bit by bit.
- Simultaneous: alu rd=2 and lsu rd=9 in the same cycle, FIFO empty -> ALU writes rd=2 at +1 and LSU writes rd=9 at +2.
- Starvation with STARVE_LIMIT=8: one LSU entry (rd=4) plus alu_valid held high -> stall_req high for exactly one cycle after 8 blocked cycles. Bench drops alu_valid in that cycle -> rd=4 written the next cycle, and stall_req returns to 0.
- Mid-drain reset: 3 entries buffered, assert rst -> no further wr_en=1, mask=0, count=0 after the edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// LSU result handshake bundle for the write-back arbiter.
// master: LSU side (drives valid/rd/data); slave: arbiter side (drives ready).
interface regfile_wb_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  lsu_valid;
   logic                  lsu_ready;
   logic [4:0]            lsu_rd;
   logic [DATA_WIDTH-1:0] lsu_data;

   modport master (
      output lsu_valid,
      output lsu_rd,
      output lsu_data,
      input  lsu_ready
   );

   modport slave (
      input  lsu_valid,
      input  lsu_rd,
      input  lsu_data,
      output lsu_ready
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: merges ALU and buffered LSU results onto one rf port.
// Ports: clk, rst (sync, active-high), alu_valid/rd/data, lsu (slave),
//        wr_en/addr/data, lsu_pend_mask (pending LSU rd), stall_req.
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [4:0]            alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   regfile_wb_arbiter_if.slave   lsu,
   output logic                  wr_en,
   output logic [4:0]            wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic [31:0]           lsu_pend_mask,
   output logic                  stall_req
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   localparam logic [PW:0] FULL =
      (PW+1)'(FIFO_DEPTH);
   localparam logic [SW-1:0] FIRE =
      SW'(STARVE_LIMIT - 1);
   localparam logic [SW-1:0] SAT =
      SW'(STARVE_LIMIT);

   logic [4:0]            q_rd   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] q_vld;
   logic [FIFO_DEPTH-1:0] vld_nxt;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW:0]           count;
   logic [SW-1:0]         starve;

   logic                  fifo_ne;
   logic                  push;
   logic                  pop;
   logic                  gnt_alu;
   logic                  blocked;
   logic [4:0]            gnt_rd;
   logic [DATA_WIDTH-1:0] gnt_data;

   assign fifo_ne = (count != '0);

   // Ready looks only at registered occupancy, so
   // a full FIFO refuses even when it pops this cycle.
   assign lsu.lsu_ready = !rst && (count != FULL);
   assign push = lsu.lsu_valid && lsu.lsu_ready;

   // stall_req only ever asks the ALU to go quiet;
   // if it still shows up, it wins, so the FIFO
   // head is taken exactly when no ALU result.
   always_comb begin
      gnt_alu  = 1'b0;
      pop      = 1'b0;
      gnt_rd   = alu_rd;
      gnt_data = alu_data;
      priority case (1'b1)
         alu_valid: gnt_alu = 1'b1;
         fifo_ne: begin
            pop      = 1'b1;
            gnt_rd   = q_rd[rd_ptr];
            gnt_data = q_data[rd_ptr];
         end
         default: ;
      endcase
   end

   assign blocked = gnt_alu && fifo_ne;

   always_comb begin
      lsu_pend_mask = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (q_vld[i]) begin
            lsu_pend_mask[q_rd[i]] = 1'b1;
         end
      end
      lsu_pend_mask[0] = 1'b0;
   end

   // A full FIFO never pushes, so the popped and
   // pushed slots cannot collide.
   always_comb begin
      vld_nxt = q_vld;
      if (pop) begin
         vld_nxt[rd_ptr] = 1'b0;
      end
      if (push) begin
         vld_nxt[wr_ptr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wr_ptr]   <= lsu.lsu_rd;
         q_data[wr_ptr] <= lsu.lsu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         q_vld  <= '0;
      end else begin
         q_vld <= vld_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Counter saturates past the firing point so a
   // still-blocked stall cycle cannot re-fire.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve    <= '0;
         stall_req <= 1'b0;
      end else begin
         if (pop || !fifo_ne) begin
            starve <= '0;
         end else if (blocked && starve != SAT) begin
            starve <= starve + 1'b1;
         end
         stall_req <= blocked && (starve == FIRE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else if (gnt_alu || pop) begin
         wr_en   <= (gnt_rd != 5'd0);
         wr_addr <= gnt_rd;
         wr_data <= gnt_data;
      end else begin
         wr_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed table plus random vs queue model.
// Drives ALU/LSU inputs, checks write port, ready, mask and stall_req.
module tb_regfile_wb_arbiter;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid;
   logic [4:0]    alu_rd;
   logic [DW-1:0] alu_data;
   logic          wr_en;
   logic [4:0]    wr_addr;
   logic [DW-1:0] wr_data;
   logic [31:0]   lsu_pend_mask;
   logic          stall_req;

   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.DATA_WIDTH(DW)) lsu_if ();

   regfile_wb_arbiter #(
      .DATA_WIDTH   (DW),
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .alu_valid     (alu_valid),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .lsu           (lsu_if),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .lsu_pend_mask (lsu_pend_mask),
      .stall_req     (stall_req)
   );

   ap_no_alu_in_stall: assert property (
      @(posedge clk) disable iff (rst)
      !(alu_valid && stall_req)
   ) else $error("alu_valid driven during stall_req");

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [4:0]    rd;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          mq[$];
   logic          m_wen;
   logic [4:0]    m_waddr;
   logic [DW-1:0] m_wdata;
   logic          m_stall;
   int            run;

   typedef struct {
      logic          r;
      logic          av;
      logic [4:0]    ard;
      logic [DW-1:0] ad;
      logic          lv;
      logic [4:0]    lrd;
      logic [DW-1:0] ld;
      logic          rdy;
      logic [31:0]   mk;
      logic          we;
      logic [4:0]    wa;
      logic [DW-1:0] wd;
      logic          st;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic m_ready();
      return !rst && (mq.size() < DEPTH);
   endfunction

   function automatic logic [31:0] m_mask();
      logic [31:0] m;
      m = '0;
      foreach (mq[i]) begin
         if (mq[i].rd != 5'd0) m[mq[i].rd] = 1'b1;
      end
      return m;
   endfunction

   // Spec-level model: one edge given current inputs.
   task automatic m_edge();
      logic acc;
      logic had;
      logic popped;
      ent_t e;
      if (rst) begin
         mq.delete();
         m_wen   = 1'b0;
         m_waddr = '0;
         m_wdata = '0;
         m_stall = 1'b0;
         run     = 0;
      end else begin
         acc    = lsu_if.lsu_valid && (mq.size() < DEPTH);
         had    = (mq.size() > 0);
         popped = 1'b0;
         if (alu_valid) begin
            m_wen   = (alu_rd != 5'd0);
            m_waddr = alu_rd;
            m_wdata = alu_data;
         end else if (had) begin
            e       = mq.pop_front();
            m_wen   = (e.rd != 5'd0);
            m_waddr = e.rd;
            m_wdata = e.data;
            popped  = 1'b1;
         end else begin
            m_wen = 1'b0;
         end
         if (!had || popped) begin
            run     = 0;
            m_stall = 1'b0;
         end else begin
            run++;
            m_stall = (run == LIMIT);
         end
         if (acc) begin
            e.rd   = lsu_if.lsu_rd;
            e.data = lsu_if.lsu_data;
            mq.push_back(e);
         end
      end
   endtask

   task automatic cyc();
      chk("m_ready", {31'd0, lsu_if.lsu_ready}, {31'd0, m_ready()});
      chk("m_mask", lsu_pend_mask, m_mask());
      m_edge();
      @(posedge clk);
      #1;
      chk("m_wr_en", {31'd0, wr_en}, {31'd0, m_wen});
      chk("m_wr_addr", {27'd0, wr_addr}, {27'd0, m_waddr});
      chk("m_wr_data", wr_data, m_wdata);
      chk("m_stall", {31'd0, stall_req}, {31'd0, m_stall});
   endtask

   task automatic add(input logic r, input logic av,
                      input logic [4:0] ard,
                      input logic [31:0] ad,
                      input logic lv,
                      input logic [4:0] lrd,
                      input logic [31:0] ld,
                      input logic rdy,
                      input logic [31:0] mk,
                      input logic we,
                      input logic [4:0] wa,
                      input logic [31:0] wd,
                      input logic st);
      vec_t v;
      v.r = r;     v.av = av;   v.ard = ard;
      v.ad = ad;   v.lv = lv;   v.lrd = lrd;
      v.ld = ld;   v.rdy = rdy; v.mk = mk;
      v.we = we;   v.wa = wa;   v.wd = wd;
      v.st = st;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic av,
                        input logic [4:0] ard,
                        input logic [31:0] ad,
                        input logic lv,
                        input logic [4:0] lrd,
                        input logic [31:0] ld);
      rst              = r;
      alu_valid        = av;
      alu_rd           = ard;
      alu_data         = ad;
      lsu_if.lsu_valid = lv;
      lsu_if.lsu_rd    = lrd;
      lsu_if.lsu_data  = ld;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic heavy;
      logic av;
      drive(1, 0, 0, 0, 0, 0, 0);
      m_edge();
      @(posedge clk);
      #1;

      // reset held with lsu_valid high
      for (int i = 0; i < 3; i++)
         add(1,0,0,0, 1,1,32'hAA, 0,0, 0,0,0,0);
      add(0,0,0,0, 0,0,0, 1,0, 0,0,0,0);
      // ALU only
      add(0,1,3,32'hDEADBEEF, 0,0,0,
          1,0, 1,3,32'hDEADBEEF,0);
      add(0,1,0,32'h1234, 0,0,0,
          1,0, 0,0,32'h1234,0);
      add(0,0,0,0, 0,0,0, 1,0, 0,0,32'h1234,0);
      // fill FIFO under ALU traffic
      add(0,1,1,32'h100, 1,5,32'h11,
          1,32'h000, 1,1,32'h100,0);
      add(0,1,1,32'h101, 1,6,32'h22,
          1,32'h020, 1,1,32'h101,0);
      add(0,1,1,32'h102, 1,7,32'h33,
          1,32'h060, 1,1,32'h102,0);
      add(0,1,1,32'h103, 1,8,32'h44,
          1,32'h0E0, 1,1,32'h103,0);
      add(0,1,1,32'h104, 1,9,32'h55,
          0,32'h1E0, 1,1,32'h104,0);
      // drain in order
      add(0,0,0,0, 0,0,0, 0,32'h1E0, 1,5,32'h11,0);
      add(0,0,0,0, 0,0,0, 1,32'h1C0, 1,6,32'h22,0);
      add(0,0,0,0, 0,0,0, 1,32'h180, 1,7,32'h33,0);
      add(0,0,0,0, 0,0,0, 1,32'h100, 1,8,32'h44,0);
      add(0,0,0,0, 0,0,0, 1,32'h000, 0,8,32'h44,0);
      // simultaneous ALU and LSU
      add(0,1,2,32'h2222, 1,9,32'h9999,
          1,0, 1,2,32'h2222,0);
      add(0,0,0,0, 0,0,0, 1,32'h200, 1,9,32'h9999,0);
      add(0,0,0,0, 0,0,0, 1,0, 0,9,32'h9999,0);
      // starvation
      add(0,0,0,0, 1,4,32'h4444, 1,0, 0,9,32'h9999,0);
      for (int i = 0; i < 8; i++)
         add(0,1,1,32'h200 + i, 0,0,0,
             1,32'h10, 1,1,32'h200 + i, (i == 7));
      add(0,0,0,0, 0,0,0, 1,32'h10, 1,4,32'h4444,0);
      add(0,0,0,0, 0,0,0, 1,0, 0,4,32'h4444,0);
      // reset while draining
      add(0,1,1,32'h300, 1,10,32'hA,
          1,32'h000, 1,1,32'h300,0);
      add(0,1,1,32'h301, 1,11,32'hB,
          1,32'h400, 1,1,32'h301,0);
      add(0,1,1,32'h302, 1,12,32'hC,
          1,32'hC00, 1,1,32'h302,0);
      add(1,0,0,0, 0,0,0, 0,32'h1C00, 0,0,0,0);
      add(0,0,0,0, 0,0,0, 1,0, 0,0,0,0);
      add(0,0,0,0, 0,0,0, 1,0, 0,0,0,0);

      foreach (vecs[i]) begin
         drive(vecs[i].r, vecs[i].av, vecs[i].ard,
               vecs[i].ad, vecs[i].lv, vecs[i].lrd,
               vecs[i].ld);
         #1;
         chk($sformatf("v%0d_ready", i),
             {31'd0, lsu_if.lsu_ready},
             {31'd0, vecs[i].rdy});
         chk($sformatf("v%0d_mask", i),
             lsu_pend_mask, vecs[i].mk);
         cyc();
         chk($sformatf("v%0d_wr_en", i),
             {31'd0, wr_en}, {31'd0, vecs[i].we});
         chk($sformatf("v%0d_wr_addr", i),
             {27'd0, wr_addr}, {27'd0, vecs[i].wa});
         chk($sformatf("v%0d_wr_data", i),
             wr_data, vecs[i].wd);
         chk($sformatf("v%0d_stall", i),
             {31'd0, stall_req}, {31'd0, vecs[i].st});
      end

      for (int i = 0; i < 3000; i++) begin
         heavy = ((i / 300) % 2) == 1;
         av = heavy ? ($urandom_range(0, 99) < 92)
                    : ($urandom_range(0, 99) < 40);
         drive($urandom_range(0, 199) == 0,
               av && !m_stall,
               5'($urandom_range(0, 31)),
               $urandom(),
               $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 31)),
               $urandom());
         #1;
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
